ps2_key_tracker: RTL and testbench

Parametrised PS/2 scan-code decoder that sits directly behind `PS2_Controller`, consuming its received-byte strobe and tracking the held/released state of a configurable set of keys. It decodes Set-2 make, break (`F0`), extended (`E0`) and Pause (`E1`) sequences and drops stale prefixes with a timeout. It presents per-key level outputs plus one-cycle press/release pulses to game logic, replacing ad-hoc single-key latches.

---
 rtl/ps2_key_tracker.sv | 181 ++++++++++++++++++
 tb/tb_ps2_key_tracker.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker.sv
// PS/2 Set-2 scan-code decoder behind PS2_Controller: tracks held state of a
// configurable key set and emits registered press/release pulses.
module ps2_key_tracker #(
   parameter int                    NUM_KEYS         = 8,
   parameter logic [9*NUM_KEYS-1:0] KEY_CODES        = {9'h172, 9'h175, 9'h029, 9'h04D,
                                                        9'h023, 9'h01B, 9'h01C, 9'h01D},
   parameter bit                    TYPEMATIC_FILTER = 1'b1,
   parameter int                    TIMEOUT_CYCLES   = 2_500_000
) (
   input  logic                CLOCK_50,
   input  logic                reset,
   input  logic [7:0]          rx_data,
   input  logic                rx_valid,
   output logic [NUM_KEYS-1:0] key_down,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic                any_down,
   output logic [8:0]          last_code,
   output logic                last_break,
   output logic                protocol_error
);

   localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      EXT,
      BRK,
      EXT_BRK,
      PAUSE
   } state_t;

   state_t              state_q, state_d;
   logic [2:0]          skip_q, skip_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic                err_q, err_d;
   logic [NUM_KEYS-1:0] key_down_q, key_down_d;
   logic [NUM_KEYS-1:0] key_press_q, key_press_d;
   logic [NUM_KEYS-1:0] key_release_q, key_release_d;
   logic [NUM_KEYS-1:0] key_match;
   logic                any_down_q, any_down_d;
   logic [8:0]          last_code_q, last_code_d;
   logic                last_break_q, last_break_d;

   logic                done_make;
   logic                done_brk;
   logic [8:0]          done_code;

   // Byte decoder; an arriving byte always takes priority over a timeout.
   always_comb begin
      state_d   = state_q;
      skip_d    = skip_q;
      tmo_d     = tmo_q;
      err_d     = 1'b0;
      done_make = 1'b0;
      done_brk  = 1'b0;
      done_code = 9'h000;
      if (rx_valid) begin
         tmo_d = '0;
         case (state_q)
            IDLE: begin
               case (rx_data)
                  8'hE0: state_d = EXT;
                  8'hF0: state_d = BRK;
                  8'hE1: begin
                     state_d = PAUSE;
                     skip_d  = 3'd7;
                  end
                  8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: state_d = IDLE;
                  default: begin
                     done_make = 1'b1;
                     done_code = {1'b0, rx_data};
                  end
               endcase
            end
            EXT: begin
               if (rx_data == 8'hE0) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end else if (rx_data == 8'hF0) begin
                  state_d = EXT_BRK;
               end else begin
                  done_make = 1'b1;
                  done_code = {1'b1, rx_data};
                  state_d   = IDLE;
               end
            end
            BRK: begin
               state_d = IDLE;
               if (rx_data == 8'hE0 || rx_data == 8'hF0) begin
                  err_d = 1'b1;
               end else begin
                  done_brk  = 1'b1;
                  done_code = {1'b0, rx_data};
               end
            end
            EXT_BRK: begin
               state_d = IDLE;
               if (rx_data == 8'hE0) begin
                  err_d = 1'b1;
               end else begin
                  done_brk  = 1'b1;
                  done_code = {1'b1, rx_data};
               end
            end
            PAUSE: begin
               skip_d = (skip_q == 3'd0) ? 3'd0 : skip_q - 3'd1;
               if (skip_q <= 3'd1) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end else if (state_q != IDLE) begin
         if (tmo_q == TMO_LAST) begin
            err_d   = 1'b1;
            state_d = IDLE;
            skip_d  = 3'd0;
            tmo_d   = '0;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end
   end

   // Every table entry equal to the completed code is updated, so duplicates all follow.
   for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      assign key_match[gi]     = (KEY_CODES[gi*9 +: 9] == done_code);
      assign key_down_d[gi]    = (key_match[gi] && done_make) ? 1'b1 :
                                 (key_match[gi] && done_brk)  ? 1'b0 : key_down_q[gi];
      assign key_press_d[gi]   = key_match[gi] && done_make &&
                                 (!key_down_q[gi] || !TYPEMATIC_FILTER);
      assign key_release_d[gi] = key_match[gi] && done_brk && key_down_q[gi];
   end

   always_comb begin
      any_down_d   = |key_down_d;
      last_code_d  = last_code_q;
      last_break_d = last_break_q;
      if (done_make || done_brk) begin
         last_code_d  = done_code;
         last_break_d = done_brk;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q       <= IDLE;
         skip_q        <= 3'd0;
         tmo_q         <= '0;
         err_q         <= 1'b0;
         key_down_q    <= '0;
         key_press_q   <= '0;
         key_release_q <= '0;
         any_down_q    <= 1'b0;
         last_code_q   <= 9'h000;
         last_break_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         skip_q        <= skip_d;
         tmo_q         <= tmo_d;
         err_q         <= err_d;
         key_down_q    <= key_down_d;
         key_press_q   <= key_press_d;
         key_release_q <= key_release_d;
         any_down_q    <= any_down_d;
         last_code_q   <= last_code_d;
         last_break_q  <= last_break_d;
      end
   end

   assign key_down       = key_down_q;
   assign key_press      = key_press_q;
   assign key_release    = key_release_q;
   assign any_down       = any_down_q;
   assign last_code      = last_code_q;
   assign last_break     = last_break_q;
   assign protocol_error = err_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: one instance with the typematic filter,
// one without, both fed the same byte stream and checked through a scoreboard.
module tb_ps2_key_tracker;

   localparam int TMO = 40;

   logic       clk;
   logic       reset;
   logic [7:0] rx_data;
   logic       rx_valid;

   logic [7:0] key_down, key_press, key_release;
   logic       any_down, last_break, protocol_error;
   logic [8:0] last_code;

   logic [7:0] nf_down, nf_press, nf_release;
   logic       nf_any, nf_last_break, nf_err;
   logic [8:0] nf_last_code;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      string      tag;
      logic [7:0] down;
      logic [7:0] press;
      logic [7:0] rel;
      logic       err;
      logic [7:0] nf_press;
   } exp_t;

   exp_t sb_q[$];

   ps2_key_tracker #(
      .TYPEMATIC_FILTER(1'b1),
      .TIMEOUT_CYCLES  (TMO)
   ) dut (
      .CLOCK_50      (clk),
      .reset         (reset),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .key_down      (key_down),
      .key_press     (key_press),
      .key_release   (key_release),
      .any_down      (any_down),
      .last_code     (last_code),
      .last_break    (last_break),
      .protocol_error(protocol_error)
   );

   ps2_key_tracker #(
      .TYPEMATIC_FILTER(1'b0),
      .TIMEOUT_CYCLES  (TMO)
   ) dut_nf (
      .CLOCK_50      (clk),
      .reset         (reset),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .key_down      (nf_down),
      .key_press     (nf_press),
      .key_release   (nf_release),
      .any_down      (nf_any),
      .last_code     (nf_last_code),
      .last_break    (nf_last_break),
      .protocol_error(nf_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input string tag, input logic [7:0] down, input logic [7:0] press,
                           input logic [7:0] rel, input logic err, input logic [7:0] nfp);
      exp_t e;
      e.tag      = tag;
      e.down     = down;
      e.press    = press;
      e.rel      = rel;
      e.err      = err;
      e.nf_press = nfp;
      sb_q.push_back(e);
   endtask

   task automatic pop_check();
      exp_t e;
      if (sb_q.size() == 0) begin
         chk("scoreboard_empty", 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         $display("txn %s: down=%h press=%h rel=%h err=%b last_code=%h brk=%b",
                  e.tag, key_down, key_press, key_release, protocol_error, last_code, last_break);
         chk({e.tag, ".down"},     32'(key_down),       32'(e.down));
         chk({e.tag, ".press"},    32'(key_press),      32'(e.press));
         chk({e.tag, ".release"},  32'(key_release),    32'(e.rel));
         chk({e.tag, ".err"},      32'(protocol_error), 32'(e.err));
         chk({e.tag, ".any"},      32'(any_down),       32'(e.down != 8'h00));
         chk({e.tag, ".nf_press"}, 32'(nf_press),       32'(e.nf_press));
      end
   endtask

   // One byte per call; successive calls put rx_valid on consecutive edges.
   task automatic step(input string tag, input logic [7:0] b, input logic [7:0] down,
                       input logic [7:0] press, input logic [7:0] rel, input logic err,
                       input logic [7:0] nfp);
      push_exp(tag, down, press, rel, err, nfp);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      pop_check();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(posedge clk);
      #1;
   endtask

   initial begin
      int err_cycles;
      reset    = 1'b1;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      push_exp("reset", 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
      pop_check();
      chk("reset.last_code", 32'(last_code), 32'h000);
      chk("reset.last_break", 32'(last_break), 32'h0);
      @(negedge clk);
      reset = 1'b0;

      // Make and break of W (key 0).
      step("w_make",  8'h1D, 8'h01, 8'h01, 8'h00, 1'b0, 8'h01);
      chk("w_make.last_code", 32'(last_code), 32'h01D);
      chk("w_make.last_break", 32'(last_break), 32'h0);
      step("w_f0",    8'hF0, 8'h01, 8'h00, 8'h00, 1'b0, 8'h00);
      step("w_brk",   8'h1D, 8'h00, 8'h00, 8'h01, 1'b0, 8'h00);
      chk("w_brk.last_code", 32'(last_code), 32'h01D);
      chk("w_brk.last_break", 32'(last_break), 32'h1);

      // Extended Up arrow (key 6); plain 75 is a different code.
      step("up_e0",   8'hE0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
      step("up_make", 8'h75, 8'h40, 8'h40, 8'h00, 1'b0, 8'h40);
      chk("up_make.last_code", 32'(last_code), 32'h175);
      step("up_e0b",  8'hE0, 8'h40, 8'h00, 8'h00, 1'b0, 8'h00);
      step("up_f0",   8'hF0, 8'h40, 8'h00, 8'h00, 1'b0, 8'h00);
      step("up_brk",  8'h75, 8'h00, 8'h00, 8'h40, 1'b0, 8'h00);
      chk("up_brk.last_code", 32'(last_code), 32'h175);
      chk("up_brk.last_break", 32'(last_break), 32'h1);
      step("kp8",     8'h75, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
      chk("kp8.last_code", 32'(last_code), 32'h075);

      // Typematic repeat of Space (key 5).
      step("sp_1",    8'h29, 8'h20, 8'h20, 8'h00, 1'b0, 8'h20);
      step("sp_2",    8'h29, 8'h20, 8'h00, 8'h00, 1'b0, 8'h20);
      step("sp_3",    8'h29, 8'h20, 8'h00, 8'h00, 1'b0, 8'h20);
      step("sp_f0",   8'hF0, 8'h20, 8'h00, 8'h00, 1'b0, 8'h00);
      step("sp_brk",  8'h29, 8'h00, 8'h00, 8'h20, 1'b0, 8'h00);
      step("sp_brk2", 8'hF0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
      step("sp_nohld",8'h29, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);

      // Hold S, then a stale F0 prefix times out without touching key_down.
      step("s_make",  8'h1B, 8'h04, 8'h04, 8'h00, 1'b0, 8'h04);
      step("tmo_f0",  8'hF0, 8'h04, 8'h00, 8'h00, 1'b0, 8'h00);
      err_cycles = 0;
      for (int i = 0; i < 3 * TMO; i++) begin
         @(posedge clk);
         #1;
         if (protocol_error) err_cycles++;
      end
      chk("tmo.err_pulses", 32'(err_cycles), 32'd1);
      chk("tmo.down", 32'(key_down), 32'h04);
      step("a_make",  8'h1C, 8'h06, 8'h02, 8'h00, 1'b0, 8'h02);

      // Double F0 is malformed.
      step("ff_1",    8'hF0, 8'h06, 8'h00, 8'h00, 1'b0, 8'h00);
      step("ff_2",    8'hF0, 8'h06, 8'h00, 8'h00, 1'b1, 8'h00);
      chk("ff_2.nf_err", 32'(nf_err), 32'h1);

      // Pause sequence is skipped entirely, then D (key 3).
      step("p_e1",    8'hE1, 8'h06, 8'h00, 8'h00, 1'b0, 8'h00);
      step("p_14",    8'h14, 8'h06, 8'h00, 8'h00, 1'b0, 8'h00);
      step("p_77",    8'h77, 8'h06, 8'h00, 8'h00, 1'b0, 8'h00);
      step("p_e1b",   8'hE1, 8'h06, 8'h00, 8'h00, 1'b0, 8'h00);
      step("p_f0",    8'hF0, 8'h06, 8'h00, 8'h00, 1'b0, 8'h00);
      step("p_14b",   8'h14, 8'h06, 8'h00, 8'h00, 1'b0, 8'h00);
      step("p_f0b",   8'hF0, 8'h06, 8'h00, 8'h00, 1'b0, 8'h00);
      step("p_77b",   8'h77, 8'h06, 8'h00, 8'h00, 1'b0, 8'h00);
      chk("pause.last_code", 32'(last_code), 32'h01C);
      step("d_make",  8'h23, 8'h0E, 8'h08, 8'h00, 1'b0, 8'h08);

      // Release everything, hold W and A, then reset with a coincident byte.
      step("c_f0a",   8'hF0, 8'h0E, 8'h00, 8'h00, 1'b0, 8'h00);
      step("c_s",     8'h1B, 8'h0A, 8'h00, 8'h04, 1'b0, 8'h00);
      step("c_f0b",   8'hF0, 8'h0A, 8'h00, 8'h00, 1'b0, 8'h00);
      step("c_a",     8'h1C, 8'h08, 8'h00, 8'h02, 1'b0, 8'h00);
      step("c_f0c",   8'hF0, 8'h08, 8'h00, 8'h00, 1'b0, 8'h00);
      step("c_d",     8'h23, 8'h00, 8'h00, 8'h08, 1'b0, 8'h00);
      step("h_w",     8'h1D, 8'h01, 8'h01, 8'h00, 1'b0, 8'h01);
      step("h_a",     8'h1C, 8'h03, 8'h02, 8'h00, 1'b0, 8'h02);
      push_exp("rst2", 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
      @(negedge clk);
      reset    = 1'b1;
      rx_data  = 8'h1B;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      pop_check();
      chk("rst2.last_code", 32'(last_code), 32'h000);
      @(negedge clk);
      reset = 1'b0;
      step("r_f0",    8'hF0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
      step("r_w",     8'h1D, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
      chk("r_w.last_break", 32'(last_break), 32'h1);

      // Reset in the middle of an F0 prefix: the next byte is a make.
      step("m_f0",    8'hF0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      step("m_w",     8'h1D, 8'h01, 8'h01, 8'h00, 1'b0, 8'h01);
      chk("m_w.last_break", 32'(last_break), 32'h0);

      idle(2);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
